sd_cmd_engine: RTL and testbench

Hardware sequencer for the SD card CMD line, replacing bit-banged PIO control of sd_clk/sd_cmd in the Nios SD-card system. Software (or a host FSM) issues a command index and argument. The block generates the divided SD clock, serialises the 48-bit command frame with CRC7, and optionally waits for and captures a 48-bit response, checking its CRC. It sits between the processor's register interface and the sd_clk/sd_cmd pads. The DAT lines are out of scope.

---
 rtl/sd_pkg.sv | 19 +
 rtl/sd_cmd_engine_if.sv | 23 ++
 rtl/sd_crc7.sv | 33 +++
 rtl/sd_cmd_engine.sv | 238 +++++++++++++++++++++++
 tb/tb_sd_cmd_engine.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD CMD-line sequencer.
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_START,
    RECV,
    TRAIL,
    DONE
  } sd_state_e;

  localparam int SD_FRAME_BITS = 48;
  localparam int SD_NRC        = 8;
  // Bits of a frame covered by CRC7 (start, dir, index/cmd field, argument).
  localparam int SD_CRC_SPAN   = 40;
  localparam logic [6:0] CRC7_POLY = 7'h09;

endpackage

// File: rtl/sd_cmd_engine_if.sv
// Host-side command/status bundle of the SD CMD engine.
interface sd_cmd_engine_if;
  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        resp_expected;
  logic        resp_check_crc;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        crc_err;
  logic [47:0] resp;

  modport master (
    output start, cmd_index, cmd_arg, resp_expected, resp_check_crc,
    input  busy, done, timeout, crc_err, resp
  );

  modport slave (
    input  start, cmd_index, cmd_arg, resp_expected, resp_check_crc,
    output busy, done, timeout, crc_err, resp
  );
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1), MSB first; shared by the transmit and receive paths.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    fb    = bit_in ^ crc_q[6];
    crc_d = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) crc_q <= '0;
    else       crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD-line sequencer: divided sd_clk, 48-bit command with CRC7, optional
// 48-bit response capture with CRC check and start-bit timeout.
//
// state      | meaning
// IDLE       | waiting for start, sd_clk parked low
// SEND       | shifting the command frame out on fall ticks
// WAIT_START | CMD released, sampling for the response start bit
// RECV       | capturing the remaining 47 response bits on rise ticks
// TRAIL      | Nrc clock periods with CMD released
// DONE       | one-cycle done pulse, back to IDLE
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter int CLK_DIV      = 125,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset,
  sd_cmd_engine_if.slave host,
  output logic           sd_clk,
  output logic           sd_cmd_out,
  output logic           sd_cmd_oe,
  input  logic           sd_cmd_in
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int WW = $clog2(RESP_TIMEOUT + 1);

  sd_state_e   state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic        sd_clk_q, sd_clk_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic        crc_err_q, crc_err_d;
  logic [47:0] resp_q, resp_d;
  logic [47:0] tx_q, tx_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [5:0]  rx_cnt_q, rx_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [3:0]  trail_cnt_q, trail_cnt_d;
  logic        oe_q, oe_d;
  logic        out_q, out_d;
  logic        rexp_q, rexp_d;
  logic        chk_q, chk_d;

  logic        wrap, rise_tick, fall_tick;
  logic        crc_clear, crc_en, crc_bit;
  logic [6:0]  crc_val;

  assign wrap      = busy_q && (div_q == DW'(CLK_DIV - 1));
  assign rise_tick = wrap && !sd_clk_q;
  assign fall_tick = wrap && sd_clk_q;

  sd_crc7 u_crc7 (
    .clk    (clk),
    .reset  (reset),
    .clear  (crc_clear),
    .en     (crc_en),
    .bit_in (crc_bit),
    .crc    (crc_val)
  );

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    sd_clk_d    = sd_clk_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    timeout_d   = timeout_q;
    crc_err_d   = crc_err_q;
    resp_d      = resp_q;
    tx_d        = tx_q;
    bit_cnt_d   = bit_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    trail_cnt_d = trail_cnt_q;
    oe_d        = oe_q;
    out_d       = out_q;
    rexp_d      = rexp_q;
    chk_d       = chk_q;
    crc_clear   = 1'b0;
    crc_en      = 1'b0;
    crc_bit     = 1'b0;

    if (!busy_q) begin
      div_d    = '0;
      sd_clk_d = 1'b0;
    end else if (wrap) begin
      div_d    = '0;
      sd_clk_d = ~sd_clk_q;
    end else begin
      div_d = div_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (host.start) begin
          state_d    = SEND;
          busy_d     = 1'b1;
          timeout_d  = 1'b0;
          crc_err_d  = 1'b0;
          resp_d     = '0;
          tx_d       = {2'b01, host.cmd_index, host.cmd_arg, 8'h00};
          bit_cnt_d  = '0;
          wait_cnt_d = '0;
          oe_d       = 1'b1;
          out_d      = 1'b0;
          rexp_d     = host.resp_expected;
          chk_d      = host.resp_check_crc;
          crc_clear  = 1'b1;
        end
      end
      SEND: begin
        // CRC is fed mid-bit so it is complete by the fall tick that loads it.
        if (rise_tick && bit_cnt_q < 6'(SD_CRC_SPAN)) begin
          crc_en  = 1'b1;
          crc_bit = tx_q[47];
        end
        if (fall_tick) begin
          if (bit_cnt_q == 6'(SD_FRAME_BITS - 1)) begin
            oe_d  = 1'b0;
            out_d = 1'b1;
            if (rexp_q) begin
              state_d = WAIT_START;
            end else begin
              state_d     = TRAIL;
              trail_cnt_d = 4'(SD_NRC);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 6'(SD_CRC_SPAN - 1)) tx_d = {crc_val, 1'b1, 40'h0};
            else                                  tx_d = {tx_q[46:0], 1'b0};
            out_d = tx_d[47];
          end
        end
      end
      WAIT_START: begin
        if (rise_tick) begin
          if (!sd_cmd_in) begin
            resp_d    = {resp_q[46:0], 1'b0};
            rx_cnt_d  = 6'd1;
            crc_clear = 1'b1;
            state_d   = RECV;
          end else if (wait_cnt_q == WW'(RESP_TIMEOUT - 1)) begin
            timeout_d   = 1'b1;
            state_d     = TRAIL;
            trail_cnt_d = 4'(SD_NRC + 1);
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end
      RECV: begin
        if (rise_tick) begin
          resp_d = {resp_q[46:0], sd_cmd_in};
          if (rx_cnt_q < 6'(SD_CRC_SPAN)) begin
            crc_en  = 1'b1;
            crc_bit = sd_cmd_in;
          end
          if (rx_cnt_q == 6'(SD_FRAME_BITS - 1)) begin
            crc_err_d   = (chk_q && (crc_val != resp_d[7:1])) || !resp_d[0];
            state_d     = TRAIL;
            // Entered on a rise tick: one extra fall closes the last bit period.
            trail_cnt_d = 4'(SD_NRC + 1);
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
      end
      TRAIL: begin
        if (fall_tick) begin
          if (trail_cnt_q == 4'd1) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            trail_cnt_d = trail_cnt_q - 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      div_q       <= '0;
      sd_clk_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      crc_err_q   <= 1'b0;
      resp_q      <= '0;
      tx_q        <= '0;
      bit_cnt_q   <= '0;
      rx_cnt_q    <= '0;
      wait_cnt_q  <= '0;
      trail_cnt_q <= '0;
      oe_q        <= 1'b0;
      out_q       <= 1'b1;
      rexp_q      <= 1'b0;
      chk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      sd_clk_q    <= sd_clk_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      crc_err_q   <= crc_err_d;
      resp_q      <= resp_d;
      tx_q        <= tx_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      trail_cnt_q <= trail_cnt_d;
      oe_q        <= oe_d;
      out_q       <= out_d;
      rexp_q      <= rexp_d;
      chk_q       <= chk_d;
    end
  end

  assign host.busy    = busy_q;
  assign host.done    = done_q;
  assign host.timeout = timeout_q;
  assign host.crc_err = crc_err_q;
  assign host.resp    = resp_q;
  assign sd_clk       = sd_clk_q;
  assign sd_cmd_oe    = oe_q;
  assign sd_cmd_out   = out_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed bench for sd_cmd_engine with CLK_DIV=2 and a CMD-line slave model.
module tb_sd_cmd_engine;

  logic clk = 1'b0;
  logic reset;
  logic sd_clk, sd_cmd_out, sd_cmd_oe;
  logic sd_cmd_in;
  int   checks   = 0;
  int   failures = 0;

  sd_cmd_engine_if hif ();

  sd_cmd_engine #(.CLK_DIV(2), .RESP_TIMEOUT(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .host       (hif),
    .sd_clk     (sd_clk),
    .sd_cmd_out (sd_cmd_out),
    .sd_cmd_oe  (sd_cmd_oe),
    .sd_cmd_in  (sd_cmd_in)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] crc7_of(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // Issues one command and plays the card: captures the host frame on sd_clk
  // rises, and (mode 1) answers W periods after release, changing on falls.
  task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg,
                         input logic rexp, input logic chk, input int mode,
                         input int w, input logic [47:0] rframe, input bit extra_starts,
                         output logic [47:0] frame, output int nbits,
                         output int done_cyc, output int ndone);
    logic prev_clk, prev_oe, released, fell;
    int   k, sbit;
    frame = '0; nbits = 0; done_cyc = -1; ndone = 0;
    released = 1'b0; k = 0; sbit = 0;
    sd_cmd_in = 1'b1;
    @(posedge clk); #1;
    hif.cmd_index = idx; hif.cmd_arg = arg;
    hif.resp_expected = rexp; hif.resp_check_crc = chk;
    hif.start = 1'b1;
    @(posedge clk); #1;
    hif.start = 1'b0;
    prev_clk = sd_clk; prev_oe = sd_cmd_oe;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      @(posedge clk); #1;
      if (extra_starts) begin
        hif.start = (cyc == 10 || cyc == 100);
        if (hif.start) hif.cmd_index = 6'h3F;
      end
      if (sd_clk && !prev_clk && sd_cmd_oe) begin
        frame = {frame[46:0], sd_cmd_out};
        nbits++;
      end
      fell = !sd_clk && prev_clk;
      if (prev_oe && !sd_cmd_oe) begin released = 1'b1; k = 0; end
      else if (released && fell) k++;
      if (mode == 1 && released && fell && k >= w) begin
        if (sbit < 48) begin sd_cmd_in = rframe[47-sbit]; sbit++; end
        else sd_cmd_in = 1'b1;
      end
      if (hif.done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      prev_clk = sd_clk; prev_oe = sd_cmd_oe;
      if (done_cyc >= 0 && cyc >= done_cyc + 12) break;
    end
    hif.start = 1'b0;
    sd_cmd_in = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; hif.start = 1'b0; hif.cmd_index = '0; hif.cmd_arg = '0;
    hif.resp_expected = 1'b0; hif.resp_check_crc = 1'b0; sd_cmd_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (hif.busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b exp=0", hif.busy); end
    checks++; if (hif.done !== 1'b0)    begin failures++; $display("FAIL reset_done got=%b exp=0", hif.done); end
    checks++; if (hif.timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", hif.timeout); end
    checks++; if (hif.crc_err !== 1'b0) begin failures++; $display("FAIL reset_crc_err got=%b exp=0", hif.crc_err); end
    checks++; if (hif.resp !== 48'h0)   begin failures++; $display("FAIL reset_resp got=%h exp=0", hif.resp); end
    checks++; if (sd_clk !== 1'b0)      begin failures++; $display("FAIL reset_sd_clk got=%b exp=0", sd_clk); end
    checks++; if (sd_cmd_oe !== 1'b0)   begin failures++; $display("FAIL reset_oe got=%b exp=0", sd_cmd_oe); end
    checks++; if (sd_cmd_out !== 1'b1)  begin failures++; $display("FAIL reset_out got=%b exp=1", sd_cmd_out); end
  endtask

  task automatic test_cmd0();
    logic [47:0] fr; int nb, dc, nd;
    run_txn(6'd0, 32'h0, 1'b0, 1'b0, 0, 0, 48'h0, 1'b0, fr, nb, dc, nd);
    checks++; if (fr !== 48'h40_0000_0000_95) begin failures++; $display("FAIL cmd0_frame got=%h exp=400000000095", fr); end
    checks++; if (nb !== 48)   begin failures++; $display("FAIL cmd0_nbits got=%0d exp=48", nb); end
    checks++; if (dc !== 224)  begin failures++; $display("FAIL cmd0_done_cycle got=%0d exp=224", dc); end
    checks++; if (nd !== 1)    begin failures++; $display("FAIL cmd0_done_pulses got=%0d exp=1", nd); end
    checks++; if (hif.timeout !== 1'b0 || hif.crc_err !== 1'b0)
      begin failures++; $display("FAIL cmd0_status got=%b%b exp=00", hif.timeout, hif.crc_err); end
    checks++; if (hif.busy !== 1'b0 || sd_clk !== 1'b0)
      begin failures++; $display("FAIL cmd0_idle got busy=%b sd_clk=%b exp=0,0", hif.busy, sd_clk); end
  endtask

  task automatic test_cmd8_resp();
    logic [47:0] fr, r7; logic [39:0] head; int nb, dc, nd;
    head = {2'b00, 6'd8, 32'h0000_01AA};
    r7   = {head, crc7_of(head), 1'b1};
    run_txn(6'd8, 32'h1AA, 1'b1, 1'b1, 1, 5, r7, 1'b0, fr, nb, dc, nd);
    checks++; if (fr !== 48'h48_0000_01AA_87) begin failures++; $display("FAIL cmd8_frame got=%h exp=48000001aa87", fr); end
    checks++; if (hif.resp !== r7)    begin failures++; $display("FAIL cmd8_resp got=%h exp=%h", hif.resp, r7); end
    checks++; if (hif.crc_err !== 1'b0) begin failures++; $display("FAIL cmd8_crc_err got=%b exp=0", hif.crc_err); end
    checks++; if (hif.timeout !== 1'b0) begin failures++; $display("FAIL cmd8_timeout got=%b exp=0", hif.timeout); end
    checks++; if (dc !== 436)  begin failures++; $display("FAIL cmd8_done_cycle got=%0d exp=436", dc); end
  endtask

  task automatic test_crc_err();
    logic [47:0] fr, r7, bad; logic [39:0] head; int nb, dc, nd;
    head = {2'b00, 6'd8, 32'h0000_01AA};
    r7   = {head, crc7_of(head), 1'b1};
    bad  = r7 ^ (48'h1 << 12);
    run_txn(6'd8, 32'h1AA, 1'b1, 1'b1, 1, 5, bad, 1'b0, fr, nb, dc, nd);
    checks++; if (hif.crc_err !== 1'b1) begin failures++; $display("FAIL crcbad_crc_err got=%b exp=1", hif.crc_err); end
    checks++; if (hif.resp !== bad)   begin failures++; $display("FAIL crcbad_resp got=%h exp=%h", hif.resp, bad); end
    checks++; if (dc !== 436)  begin failures++; $display("FAIL crcbad_done_cycle got=%0d exp=436", dc); end
    run_txn(6'd8, 32'h1AA, 1'b1, 1'b0, 1, 5, bad, 1'b0, fr, nb, dc, nd);
    checks++; if (hif.crc_err !== 1'b0) begin failures++; $display("FAIL nochk_crc_err got=%b exp=0", hif.crc_err); end
    checks++; if (hif.resp !== bad)   begin failures++; $display("FAIL nochk_resp got=%h exp=%h", hif.resp, bad); end
    bad = r7 & ~48'h1;
    run_txn(6'd8, 32'h1AA, 1'b1, 1'b0, 1, 2, bad, 1'b0, fr, nb, dc, nd);
    checks++; if (hif.crc_err !== 1'b1) begin failures++; $display("FAIL endbit_crc_err got=%b exp=1", hif.crc_err); end
    checks++; if (dc !== 424)  begin failures++; $display("FAIL endbit_done_cycle got=%0d exp=424", dc); end
  endtask

  task automatic test_timeout();
    logic [47:0] fr; int nb, dc, nd;
    run_txn(6'd55, 32'h0, 1'b1, 1'b1, 0, 0, 48'h0, 1'b0, fr, nb, dc, nd);
    checks++; if (hif.timeout !== 1'b1) begin failures++; $display("FAIL tmo_timeout got=%b exp=1", hif.timeout); end
    checks++; if (hif.resp !== 48'h0)  begin failures++; $display("FAIL tmo_resp got=%h exp=0", hif.resp); end
    checks++; if (hif.crc_err !== 1'b0) begin failures++; $display("FAIL tmo_crc_err got=%b exp=0", hif.crc_err); end
    checks++; if (dc !== 480)  begin failures++; $display("FAIL tmo_done_cycle got=%0d exp=480", dc); end
  endtask

  task automatic test_reset_mid();
    logic [47:0] fr; int nb, dc, nd;
    @(posedge clk); #1;
    hif.cmd_index = 6'd17; hif.cmd_arg = 32'hDEAD_BEEF; hif.resp_expected = 1'b0;
    hif.start = 1'b1;
    @(posedge clk); #1;
    hif.start = 1'b0;
    repeat (82) @(posedge clk);
    #1;
    checks++; if (sd_clk !== 1'b1 || sd_cmd_oe !== 1'b1)
      begin failures++; $display("FAIL mid_bit20 got sd_clk=%b oe=%b exp=1,1", sd_clk, sd_cmd_oe); end
    reset = 1'b1;
    #1;
    checks++; if (sd_clk !== 1'b0)     begin failures++; $display("FAIL mid_rst_sd_clk got=%b exp=0", sd_clk); end
    checks++; if (sd_cmd_oe !== 1'b0)  begin failures++; $display("FAIL mid_rst_oe got=%b exp=0", sd_cmd_oe); end
    checks++; if (sd_cmd_out !== 1'b1) begin failures++; $display("FAIL mid_rst_out got=%b exp=1", sd_cmd_out); end
    checks++; if (hif.busy !== 1'b0)   begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", hif.busy); end
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    run_txn(6'd0, 32'h0, 1'b0, 1'b0, 0, 0, 48'h0, 1'b0, fr, nb, dc, nd);
    checks++; if (fr !== 48'h40_0000_0000_95) begin failures++; $display("FAIL post_rst_frame got=%h exp=400000000095", fr); end
    checks++; if (dc !== 224)  begin failures++; $display("FAIL post_rst_done_cycle got=%0d exp=224", dc); end
  endtask

  task automatic test_back_to_back();
    logic [47:0] fr; int nb, dc, nd;
    run_txn(6'd0, 32'h0, 1'b0, 1'b0, 0, 0, 48'h0, 1'b1, fr, nb, dc, nd);
    checks++; if (fr !== 48'h40_0000_0000_95) begin failures++; $display("FAIL ignore_frame got=%h exp=400000000095", fr); end
    checks++; if (nd !== 1)    begin failures++; $display("FAIL ignore_done_pulses got=%0d exp=1", nd); end
    checks++; if (dc !== 224)  begin failures++; $display("FAIL ignore_done_cycle got=%0d exp=224", dc); end
    checks++; if (hif.busy !== 1'b0) begin failures++; $display("FAIL ignore_busy_after got=%b exp=0", hif.busy); end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8_resp();
    test_crc_err();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
